display_nchar_driver: RTL and testbench

//  Parametrised serial driver for the chained 4-char dot-matrix LED display modules (HCMS-style, 5x8 dots per char).

---
 rtl/display_nchar_driver.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_display_nchar_driver.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_nchar_driver.sv
// Serial driver for chained 4-char HCMS-style dot-matrix modules with per-frame snapshot and runtime brightness.
// Optional build macro ASCII_MODE_EN: one ASCII byte per char (0x20-0x7E) instead of hex nibbles.
module display_nchar_driver #(
  parameter int NUM_CHARS    = 16,
  parameter int CLK_DIV      = 26,
  parameter int RESET_CYCLES = 100
) (
  input  logic                     clock_27mhz,
  input  logic                     reset,
`ifdef ASCII_MODE_EN
  input  logic [8*NUM_CHARS-1:0]   data,
`else
  input  logic [4*NUM_CHARS-1:0]   data,
`endif
  input  logic [3:0]               brightness,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     disp_blank,
  output logic                     disp_clock,
  output logic                     disp_data_out,
  output logic                     disp_rs,
  output logic                     disp_ce_b,
  output logic                     disp_reset_b
);

`ifdef ASCII_MODE_EN
  localparam int CHW = 8;
`else
  localparam int CHW = 4;
`endif
  localparam int SH       = $clog2(CHW);
  localparam int CW       = 2 * NUM_CHARS;
  localparam int CLR_LAST = NUM_CHARS * 40 - 1;
  localparam int IDXW     = $clog2(NUM_CHARS * 40);
  localparam int CHARW    = $clog2(NUM_CHARS);
  localparam int DIVW     = $clog2(CLK_DIV + 2);
  localparam int RSTW     = $clog2(RESET_CYCLES + 2);

  typedef enum logic [2:0] {
    S_RST, S_UNRST, S_CLR, S_CLRL, S_CTRL, S_LATCH, S_DOTS
  } state_t;

  state_t                   state_q, state_d;
  logic [DIVW-1:0]          div_q;
  logic                     clk_q;
  logic [RSTW-1:0]          drst_q;
  logic [IDXW-1:0]          idx_q, idx_d;
  logic [CHARW-1:0]         char_q, char_d;
  logic [5:0]               dot_q, dot_d;
  logic [3:0]               bri_q, bri_d;
  logic [CW-1:0]            ctrl_q, ctrl_d;
  logic [CHW*NUM_CHARS-1:0] data_q, data_d;
  logic dout_q, dout_d, rs_q, rs_d, ce_b_q, ce_b_d, reset_b_q, reset_b_d;
  logic busy_q, busy_d, frame_done_q, frame_done_d, pend_q, pend_d;
  logic                     tick;
  logic [7:0]               ctrl_byte;
  logic [CHW-1:0]           code;
  logic [39:0]              glyph;

  function automatic logic [39:0] glyph_rom(input logic [CHW-1:0] c);
    glyph_rom = '0;
`ifdef ASCII_MODE_EN
    case (c)
      8'h21: glyph_rom = 40'h00005F0000;  8'h22: glyph_rom = 40'h0007000700;
      8'h23: glyph_rom = 40'h147F147F14;  8'h24: glyph_rom = 40'h242A7F2A12;
      8'h25: glyph_rom = 40'h2313086462;  8'h26: glyph_rom = 40'h3649562050;
      8'h27: glyph_rom = 40'h0005030000;  8'h28: glyph_rom = 40'h001C224100;
      8'h29: glyph_rom = 40'h0041221C00;  8'h2A: glyph_rom = 40'h14083E0814;
      8'h2B: glyph_rom = 40'h08083E0808;  8'h2C: glyph_rom = 40'h0050300000;
      8'h2D: glyph_rom = 40'h0808080808;  8'h2E: glyph_rom = 40'h0060600000;
      8'h2F: glyph_rom = 40'h2010080402;  8'h30: glyph_rom = 40'h3E5149453E;
      8'h31: glyph_rom = 40'h00427F4000;  8'h32: glyph_rom = 40'h6251494946;
      8'h33: glyph_rom = 40'h2241494936;  8'h34: glyph_rom = 40'h1814127F10;
      8'h35: glyph_rom = 40'h2745454539;  8'h36: glyph_rom = 40'h3C4A494930;
      8'h37: glyph_rom = 40'h0171090503;  8'h38: glyph_rom = 40'h3649494936;
      8'h39: glyph_rom = 40'h064949291E;  8'h3A: glyph_rom = 40'h0036360000;
      8'h3B: glyph_rom = 40'h0056360000;  8'h3C: glyph_rom = 40'h0814224100;
      8'h3D: glyph_rom = 40'h1414141414;  8'h3E: glyph_rom = 40'h0041221408;
      8'h3F: glyph_rom = 40'h0201510906;  8'h40: glyph_rom = 40'h324979413E;
      8'h41: glyph_rom = 40'h7E0909097E;  8'h42: glyph_rom = 40'h7F49494936;
      8'h43: glyph_rom = 40'h3E41414122;  8'h44: glyph_rom = 40'h7F4141413E;
      8'h45: glyph_rom = 40'h7F49494941;  8'h46: glyph_rom = 40'h7F09090901;
      8'h47: glyph_rom = 40'h3E4149497A;  8'h48: glyph_rom = 40'h7F0808087F;
      8'h49: glyph_rom = 40'h00417F4100;  8'h4A: glyph_rom = 40'h2040413F01;
      8'h4B: glyph_rom = 40'h7F08142241;  8'h4C: glyph_rom = 40'h7F40404040;
      8'h4D: glyph_rom = 40'h7F020C027F;  8'h4E: glyph_rom = 40'h7F0408107F;
      8'h4F: glyph_rom = 40'h3E4141413E;  8'h50: glyph_rom = 40'h7F09090906;
      8'h51: glyph_rom = 40'h3E4151215E;  8'h52: glyph_rom = 40'h7F09192946;
      8'h53: glyph_rom = 40'h4649494931;  8'h54: glyph_rom = 40'h01017F0101;
      8'h55: glyph_rom = 40'h3F4040403F;  8'h56: glyph_rom = 40'h1F2040201F;
      8'h57: glyph_rom = 40'h3F4038403F;  8'h58: glyph_rom = 40'h6314081463;
      8'h59: glyph_rom = 40'h0708700807;  8'h5A: glyph_rom = 40'h6151494543;
      8'h5B: glyph_rom = 40'h007F414100;  8'h5C: glyph_rom = 40'h0204081020;
      8'h5D: glyph_rom = 40'h0041417F00;  8'h5E: glyph_rom = 40'h0402010204;
      8'h5F: glyph_rom = 40'h4040404040;  8'h60: glyph_rom = 40'h0001020400;
      8'h61: glyph_rom = 40'h2054545478;  8'h62: glyph_rom = 40'h7F48444438;
      8'h63: glyph_rom = 40'h3844444420;  8'h64: glyph_rom = 40'h384444487F;
      8'h65: glyph_rom = 40'h3854545418;  8'h66: glyph_rom = 40'h087E090102;
      8'h67: glyph_rom = 40'h0C5252523E;  8'h68: glyph_rom = 40'h7F08040478;
      8'h69: glyph_rom = 40'h00447D4000;  8'h6A: glyph_rom = 40'h2040443D00;
      8'h6B: glyph_rom = 40'h7F10284400;  8'h6C: glyph_rom = 40'h00417F4000;
      8'h6D: glyph_rom = 40'h7C04180478;  8'h6E: glyph_rom = 40'h7C08040478;
      8'h6F: glyph_rom = 40'h3844444438;  8'h70: glyph_rom = 40'h7C14141408;
      8'h71: glyph_rom = 40'h081414187C;  8'h72: glyph_rom = 40'h7C08040408;
      8'h73: glyph_rom = 40'h4854545420;  8'h74: glyph_rom = 40'h043F444020;
      8'h75: glyph_rom = 40'h3C4040207C;  8'h76: glyph_rom = 40'h1C2040201C;
      8'h77: glyph_rom = 40'h3C4030403C;  8'h78: glyph_rom = 40'h4428102844;
      8'h79: glyph_rom = 40'h0C5050503C;  8'h7A: glyph_rom = 40'h4464544C44;
      8'h7B: glyph_rom = 40'h0008364100;  8'h7C: glyph_rom = 40'h00007F0000;
      8'h7D: glyph_rom = 40'h0041360800;  8'h7E: glyph_rom = 40'h1008081008;
      default: glyph_rom = '0;  // space and non-printable codes stay dark
    endcase
`else
    case (c)
      4'h0: glyph_rom = 40'h3E5149453E;  4'h1: glyph_rom = 40'h00427F4000;
      4'h2: glyph_rom = 40'h6251494946;  4'h3: glyph_rom = 40'h2241494936;
      4'h4: glyph_rom = 40'h1814127F10;  4'h5: glyph_rom = 40'h2745454539;
      4'h6: glyph_rom = 40'h3C4A494930;  4'h7: glyph_rom = 40'h0171090503;
      4'h8: glyph_rom = 40'h3649494936;  4'h9: glyph_rom = 40'h064949291E;
      4'hA: glyph_rom = 40'h7E0909097E;  4'hB: glyph_rom = 40'h7F49494936;
      4'hC: glyph_rom = 40'h3E41414122;  4'hD: glyph_rom = 40'h7F4141413E;
      4'hE: glyph_rom = 40'h7F49494941;  4'hF: glyph_rom = 40'h7F09090901;
      default: glyph_rom = '0;
    endcase
`endif
  endfunction

  // FSM steps only on the 0->1 edge of the internal clock, i.e. falling disp_clock.
  assign tick      = (div_q == DIVW'(CLK_DIV)) && !clk_q;
  assign ctrl_byte = {4'b0111, brightness};
  assign code      = data_q[{char_q, SH'(0)} +: CHW];
  assign glyph     = glyph_rom(code);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      div_q  <= '0;
      clk_q  <= 1'b0;
      drst_q <= RSTW'(RESET_CYCLES);
    end else begin
      if (div_q == DIVW'(CLK_DIV)) begin
        div_q <= '0;
        clk_q <= ~clk_q;
      end else begin
        div_q <= div_q + 1'b1;
      end
      if (drst_q != '0) drst_q <= drst_q - 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latches are inferred.
    state_d      = state_q;
    idx_d        = idx_q;
    char_d       = char_q;
    dot_d        = dot_q;
    bri_d        = bri_q;
    ctrl_d       = ctrl_q;
    data_d       = data_q;
    dout_d       = dout_q;
    rs_d         = rs_q;
    ce_b_d       = ce_b_q;
    reset_b_d    = reset_b_q;
    busy_d       = busy_q;
    pend_d       = pend_q;
    frame_done_d = 1'b0;
    if (tick) begin
      unique case (state_q)
        S_RST: begin
          reset_b_d = 1'b0;
          ce_b_d    = 1'b1;
          rs_d      = 1'b0;
          idx_d     = '0;
          state_d   = S_UNRST;
        end
        S_UNRST: begin
          reset_b_d = 1'b1;
          state_d   = S_CLR;
        end
        S_CLR: begin
          ce_b_d = 1'b0;
          dout_d = 1'b0;
          if (idx_q == IDXW'(CLR_LAST)) begin
            idx_d   = '0;
            state_d = S_CLRL;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        S_CLRL: begin
          ce_b_d  = 1'b1;
          rs_d    = 1'b1;
          ctrl_d  = {(NUM_CHARS/4){ctrl_byte}};
          bri_d   = brightness;
          idx_d   = '0;
          state_d = S_CTRL;
        end
        S_CTRL: begin
          ce_b_d = 1'b0;
          dout_d = ctrl_q[CW-1];
          ctrl_d = {ctrl_q[CW-2:0], 1'b0};
          if (idx_q == IDXW'(CW - 1)) begin
            idx_d   = '0;
            state_d = S_LATCH;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        S_LATCH: begin
          ce_b_d       = 1'b1;
          rs_d         = 1'b0;
          busy_d       = 1'b0;
          data_d       = data;
          char_d       = CHARW'(NUM_CHARS - 1);
          dot_d        = 6'd39;
          frame_done_d = pend_q;
          pend_d       = 1'b0;
          // A brightness change is folded in between frames, never mid-frame.
          if (brightness != bri_q) begin
            rs_d    = 1'b1;
            ctrl_d  = {(NUM_CHARS/4){ctrl_byte}};
            bri_d   = brightness;
            busy_d  = 1'b1;
            idx_d   = '0;
            state_d = S_CTRL;
          end else begin
            state_d = S_DOTS;
          end
        end
        S_DOTS: begin
          ce_b_d = 1'b0;
          dout_d = glyph[dot_q];
          if (dot_q == 6'd0) begin
            dot_d = 6'd39;
            if (char_q == '0) begin
              pend_d  = 1'b1;
              state_d = S_LATCH;
            end else begin
              char_d = char_q - 1'b1;
            end
          end else begin
            dot_d = dot_q - 1'b1;
          end
        end
        default: state_d = S_RST;
      endcase
    end
  end

  always_ff @(posedge clock_27mhz) begin
    if (reset || drst_q != '0) begin
      state_q      <= S_RST;
      idx_q        <= '0;
      dout_q       <= 1'b0;
      rs_q         <= 1'b0;
      ce_b_q       <= 1'b1;
      reset_b_q    <= 1'b0;
      busy_q       <= 1'b1;
      frame_done_q <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      dout_q       <= dout_d;
      rs_q         <= rs_d;
      ce_b_q       <= ce_b_d;
      reset_b_q    <= reset_b_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      pend_q       <= pend_d;
    end
  end

  // NOTE: datapath registers carry no reset; each is loaded by the FSM before it is read.
  always_ff @(posedge clock_27mhz) begin
    char_q <= char_d;
    dot_q  <= dot_d;
    bri_q  <= bri_d;
    ctrl_q <= ctrl_d;
    data_q <= data_d;
  end

  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign disp_blank    = 1'b0;
  assign disp_clock    = ~clk_q;
  assign disp_data_out = dout_q;
  assign disp_rs       = rs_q;
  assign disp_ce_b     = ce_b_q;
  assign disp_reset_b  = reset_b_q;

endmodule

// File: tb/tb_display_nchar_driver.sv
// Directed bench: 16-char and 8-char driver instances, serial stream captured on rising disp_clock.
module tb_display_nchar_driver;
  localparam int CLK_DIV = 1;
  localparam int RST_CYC = 10;
  localparam int TICK    = 2 * (CLK_DIV + 1);
  localparam int CAP     = 4096;

  logic        clock_27mhz = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] data16;
  logic [31:0] data8;
  logic [3:0]  bri16, bri8;
  logic busy16, fd16, blank16, dclk16, dout16, rs16, ce_b16, rst_b16;
  logic busy8, fd8, blank8, dclk8, dout8, rs8, ce_b8, rst_b8;

  always #5 clock_27mhz = ~clock_27mhz;

  display_nchar_driver #(.NUM_CHARS(16), .CLK_DIV(CLK_DIV), .RESET_CYCLES(RST_CYC)) u_dut16 (
    .clock_27mhz(clock_27mhz), .reset(reset), .data(data16), .brightness(bri16),
    .busy(busy16), .frame_done(fd16), .disp_blank(blank16), .disp_clock(dclk16),
    .disp_data_out(dout16), .disp_rs(rs16), .disp_ce_b(ce_b16), .disp_reset_b(rst_b16));

  display_nchar_driver #(.NUM_CHARS(8), .CLK_DIV(CLK_DIV), .RESET_CYCLES(RST_CYC)) u_dut8 (
    .clock_27mhz(clock_27mhz), .reset(reset), .data(data8), .brightness(bri8),
    .busy(busy8), .frame_done(fd8), .disp_blank(blank8), .disp_clock(dclk8),
    .disp_data_out(dout8), .disp_rs(rs8), .disp_ce_b(ce_b8), .disp_reset_b(rst_b8));

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit cap_d  [2][CAP];
  bit cap_rs [2][CAP];
  int cap_n  [2];
  int fd_cnt [2];
  int fd_t   [2];

  // Bits the display would shift in: rising disp_clock with chip enable low.
  always @(posedge dclk16)
    if (ce_b16 === 1'b0 && cap_n[0] < CAP) begin
      cap_d[0][cap_n[0]]  <= dout16;
      cap_rs[0][cap_n[0]] <= rs16;
      cap_n[0]            <= cap_n[0] + 1;
    end

  always @(posedge dclk8)
    if (ce_b8 === 1'b0 && cap_n[1] < CAP) begin
      cap_d[1][cap_n[1]]  <= dout8;
      cap_rs[1][cap_n[1]] <= rs8;
      cap_n[1]            <= cap_n[1] + 1;
    end

  always @(posedge clock_27mhz) begin
    cyc <= cyc + 1;
    if (fd16 === 1'b1) begin fd_cnt[0] <= fd_cnt[0] + 1; fd_t[0] <= cyc; end
    if (fd8 === 1'b1)  begin fd_cnt[1] <= fd_cnt[1] + 1; fd_t[1] <= cyc; end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] hexg(input logic [3:0] n);
    case (n)
      4'h0: hexg = 40'h3E5149453E;  4'h1: hexg = 40'h00427F4000;
      4'h2: hexg = 40'h6251494946;  4'h3: hexg = 40'h2241494936;
      4'h4: hexg = 40'h1814127F10;  4'h5: hexg = 40'h2745454539;
      4'h6: hexg = 40'h3C4A494930;  4'h7: hexg = 40'h0171090503;
      4'h8: hexg = 40'h3649494936;  4'h9: hexg = 40'h064949291E;
      4'hA: hexg = 40'h7E0909097E;  4'hB: hexg = 40'h7F49494936;
      4'hC: hexg = 40'h3E41414122;  4'hD: hexg = 40'h7F4141413E;
      4'hE: hexg = 40'h7F49494941;  default: hexg = 40'h7F09090901;
    endcase
  endfunction

  function automatic int zero_mism(input int inst, input int off, input int n);
    int m = 0;
    for (int i = 0; i < n; i++)
      if (cap_d[inst][off+i] !== 1'b0 || cap_rs[inst][off+i] !== 1'b0) m++;
    return m;
  endfunction

  function automatic int rs_mism(input int inst, input int off, input int n, input bit val);
    int m = 0;
    for (int i = 0; i < n; i++)
      if (cap_rs[inst][off+i] !== val) m++;
    return m;
  endfunction

  function automatic logic [63:0] bits_at(input int inst, input int off, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[62:0], cap_d[inst][off+i]};
    return v;
  endfunction

  // Expected dot stream: leftmost char first, each glyph from bit 39 down to bit 0, rs low.
  function automatic int dots_mism(input int inst, input int off, input logic [63:0] dat, input int nch);
    int m = 0;
    for (int k = 0; k < nch; k++) begin
      logic [39:0] g = hexg(dat[(nch-1-k)*4 +: 4]);
      for (int j = 0; j < 40; j++)
        if (cap_d[inst][off+k*40+j] !== g[39-j] || cap_rs[inst][off+k*40+j] !== 1'b0) m++;
    end
    return m;
  endfunction

  task automatic wait_fd(input int inst, input int target, input string tag);
    int n = 0;
    while (fd_cnt[inst] < target && n < 12000) begin
      @(negedge clock_27mhz);
      n++;
    end
    check(tag, 64'(fd_cnt[inst] >= target), 64'd1);
  endtask

  initial begin
    int t, n, tgt;
    logic [63:0] old16, new16;
    old16  = 64'h0123456789ABCDEF;
    new16  = 64'hFEDCBA9876543210;
    data16 = old16;
    data8  = 32'hA5C30F12;
    bri16  = 4'd15;
    bri8   = 4'd15;
    reset  = 1'b1;
    repeat (3) @(negedge clock_27mhz);
    check("rst_data_out", 64'(dout16), 64'd0);
    check("rst_rs", 64'(rs16), 64'd0);
    check("rst_ce_b", 64'(ce_b16), 64'd1);
    check("rst_reset_b", 64'(rst_b16), 64'd0);
    check("rst_busy", 64'(busy16), 64'd1);
    check("rst_frame_done", 64'(fd16), 64'd0);
    check("blank", 64'(blank16), 64'd0);

    reset    = 1'b0;
    cap_n[0] = 0;
    cap_n[1] = 0;
    repeat (40) @(negedge clock_27mhz);
    check("init_busy", 64'(busy16), 64'd1);
    check("init_reset_b", 64'(rst_b16), 64'd1);

    // 8-char chain: 320 clear bits, 16-bit control, 321-tick frame.
    wait_fd(1, 1, "fd8_first");
    t = fd_t[1];
    wait_fd(1, 2, "fd8_second");
    check("fd8_period", 64'(fd_t[1] - t), 64'(321 * TICK));
    check("n8_stream", 64'(cap_n[1]), 64'd976);
    check("clr8_zero", 64'(zero_mism(1, 0, 320)), 64'd0);
    check("ctrl8_word", bits_at(1, 320, 16), 64'h7F7F);
    check("ctrl8_rs", 64'(rs_mism(1, 320, 16, 1'b1)), 64'd0);
    check("dots8_first", bits_at(1, 336, 40), 64'h7E0909097E);
    check("dots8_f1", 64'(dots_mism(1, 336, 64'(data8), 8)), 64'd0);
    check("dots8_f2", 64'(dots_mism(1, 656, 64'(data8), 8)), 64'd0);

    // 16-char init, control 0x7F7F7F7F, first frame.
    wait_fd(0, 1, "fd16_first");
    check("n16_stream", 64'(cap_n[0]), 64'd1312);
    check("clr16_zero", 64'(zero_mism(0, 0, 640)), 64'd0);
    check("ctrl16_word", bits_at(0, 640, 32), 64'h7F7F7F7F);
    check("ctrl16_rs", 64'(rs_mism(0, 640, 32, 1'b1)), 64'd0);
    check("char15_glyph0", bits_at(0, 672, 40), 64'h3E5149453E);
    check("char0_glyphF", bits_at(0, 1272, 40), 64'h7F09090901);
    check("dots16_f1", 64'(dots_mism(0, 672, old16, 16)), 64'd0);
    check("busy_streaming", 64'(busy16), 64'd0);
    check("latch_ce_b", 64'(ce_b16), 64'd1);
    @(negedge clock_27mhz);
    check("fd_one_cycle", 64'(fd16), 64'd0);

    t        = fd_t[0];
    cap_n[0] = 0;
    wait_fd(0, 2, "fd16_f2");
    check("fd16_period", 64'(fd_t[0] - t), 64'(641 * TICK));
    check("n16_f2", 64'(cap_n[0]), 64'd640);
    check("dots16_f2", 64'(dots_mism(0, 0, old16, 16)), 64'd0);

    // Brightness 15 -> 3 mid-frame: frame finishes, then 0x73737373 reload.
    cap_n[0] = 0;
    repeat (200) @(negedge clock_27mhz);
    bri16 = 4'd3;
    wait_fd(0, 3, "fd16_f3");
    check("n16_f3", 64'(cap_n[0]), 64'd640);
    check("dots16_f3", 64'(dots_mism(0, 0, old16, 16)), 64'd0);
    t        = fd_t[0];
    cap_n[0] = 0;
    repeat (20) @(negedge clock_27mhz);
    check("busy_bri", 64'(busy16), 64'd1);
    check("rs_bri", 64'(rs16), 64'd1);
    wait_fd(0, 4, "fd16_f4");
    check("bri_period", 64'(fd_t[0] - t), 64'(674 * TICK));
    check("n16_f4", 64'(cap_n[0]), 64'd672);
    check("ctrl16_bri3", bits_at(0, 0, 32), 64'h73737373);
    check("ctrl16_bri3_rs", 64'(rs_mism(0, 0, 32, 1'b1)), 64'd0);
    check("dots16_f4", 64'(dots_mism(0, 32, old16, 16)), 64'd0);
    check("busy_after_bri", 64'(busy16), 64'd0);

    // Data change at dot 100: old value for this frame, new value next frame.
    cap_n[0] = 0;
    n = 0;
    while (cap_n[0] < 100 && n < 5000) begin
      @(negedge clock_27mhz);
      n++;
    end
    check("reach_dot100", 64'(cap_n[0] >= 100), 64'd1);
    data16 = new16;
    wait_fd(0, 5, "fd16_f5");
    check("n16_f5", 64'(cap_n[0]), 64'd640);
    check("dots16_f5_old", 64'(dots_mism(0, 0, old16, 16)), 64'd0);
    cap_n[0] = 0;
    wait_fd(0, 6, "fd16_f6");
    check("dots16_f6_new", 64'(dots_mism(0, 0, new16, 16)), 64'd0);
    check("f6_first_F", bits_at(0, 0, 40), 64'h7F09090901);

    // Reset during S_DOTS: reset values on the next cycle, then a full re-init.
    repeat (300) @(negedge clock_27mhz);
    reset = 1'b1;
    @(negedge clock_27mhz);
    check("mid_rst_ce_b", 64'(ce_b16), 64'd1);
    check("mid_rst_reset_b", 64'(rst_b16), 64'd0);
    check("mid_rst_busy", 64'(busy16), 64'd1);
    check("mid_rst_data_out", 64'(dout16), 64'd0);
    check("mid_rst_rs", 64'(rs16), 64'd0);
    repeat (2) @(negedge clock_27mhz);
    reset    = 1'b0;
    cap_n[0] = 0;
    tgt      = fd_cnt[0] + 1;
    wait_fd(0, tgt, "fd16_reinit");
    check("n16_reinit", 64'(cap_n[0]), 64'd1312);
    check("clr16_reinit", 64'(zero_mism(0, 0, 640)), 64'd0);
    check("ctrl16_reinit", bits_at(0, 640, 32), 64'h73737373);
    check("dots16_reinit", 64'(dots_mism(0, 672, new16, 16)), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
